// File: rtl/snes_header_finder_if.sv
// Cartridge memory read bus between the header finder (master) and the
// memory arbiter (slave). A level request is held with a stable address
// until a one-cycle acknowledge returns the byte.
interface snes_header_finder_if #(
  parameter int AW = 23
) ();
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/snes_header_finder.sv
// Locates the internal SNES header of a freshly loaded ROM image. Scores the
// LoROM, HiROM and ExHiROM candidate windows, picks the best one, pulses the
// parser reset and replays the chosen 64-byte window to the parser.
module snes_header_finder #(
  parameter int AW = 23
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [23:0]                 rom_bytes,
  snes_header_finder_if.master        mem,
  output logic                        parser_resetn,
  output logic [7:0]                  hdr_d,
  output logic                        hdr_strb,
  output logic [23:0]                 hdr_base,
  output logic [1:0]                  hdr_sel,
  output logic [3:0]                  hdr_score,
  output logic                        none_valid,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_PICK, S_RSTP, S_STREAM, S_DONE
  } state_t;

  function automatic logic [23:0] win_base(input logic [1:0] w);
    case (w)
      2'd0:    return 24'h007FC0;
      2'd1:    return 24'h00FFC0;
      default: return 24'h40FFC0;
    endcase
  endfunction

  state_t        r_state, w_state_nxt;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [5:0]    r_off;
  logic [1:0]    r_win;
  logic [2:0]    r_valid;
  logic          r_found;
  logic [7:0]    r_map, r_romsz, r_ramsz;
  logic [15:0]   r_cc, r_ck, r_vec;
  logic          r_parser_resetn;
  logic [7:0]    r_hdr_d;
  logic          r_hdr_strb;
  logic [23:0]   r_hdr_base;
  logic [1:0]    r_hdr_sel;
  logic [3:0]    r_hdr_score;
  logic          r_none_valid;

  logic          w_ack, w_last, w_map_ok;
  logic [2:0]    w_valid_in;
  logic          w_first_ok, w_next_ok;
  logic [1:0]    w_first, w_next;
  logic [3:0]    w_score;

  // An acknowledge only counts while a read is actually outstanding.
  assign w_ack  = mem.mem_ack & r_mem_req;
  assign w_last = (r_off == 6'h3F);

  // Window fit test against the loaded size; one spare bit avoids overflow.
  always_comb begin
    w_valid_in = '0;
    for (int i = 0; i < 3; i++) begin
      w_valid_in[i] = ({1'b0, win_base(2'(i))} + 25'd64) <= {1'b0, rom_bytes};
    end
  end

  // First valid window overall, and next valid window after the current one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_first_ok = 1'b0;
    w_first    = 2'd0;
    w_next_ok  = 1'b0;
    w_next     = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (r_valid[i]) begin
        w_first_ok = 1'b1;
        w_first    = 2'(i);
      end
      if (r_valid[i] && (2'(i) > r_win)) begin
        w_next_ok = 1'b1;
        w_next    = 2'(i);
      end
    end
  end

  // Plausibility score of the window whose bytes were just latched.
  always_comb begin
    case (r_win)
      2'd0:    w_map_ok = !r_map[0];
      2'd1:    w_map_ok = r_map[0] && !r_map[2];
      default: w_map_ok = (r_map[2:0] == 3'b101);
    endcase
    w_score = 4'd0;
    if (w_map_ok)                                   w_score = w_score + 4'd2;
    if (r_map[7:4] == 4'd2 || r_map[7:4] == 4'd3)   w_score = w_score + 4'd1;
    if (r_romsz >= 8'd8 && r_romsz <= 8'd13)        w_score = w_score + 4'd1;
    if (r_ramsz <= 8'd8)                            w_score = w_score + 4'd1;
    if ((r_cc ^ r_ck) == 16'hFFFF)                  w_score = w_score + 4'd2;
    if (r_vec[15])                                  w_score = w_score + 4'd1;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (!r_mem_req) begin
          if (!w_first_ok) w_state_nxt = S_PICK;
        end else if (w_ack && w_last && !w_next_ok) begin
          w_state_nxt = S_PICK;
        end
      end
      S_PICK:   w_state_nxt = S_RSTP;
      S_RSTP:   w_state_nxt = S_STREAM;
      S_STREAM: if (!r_mem_req && r_hdr_strb) w_state_nxt = S_DONE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Read sequencing, byte latching, best-window tracking and header replay.
  // NOTE: the latched header bytes are reset too; they are a handful of flops, not a RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_off           <= '0;
      r_win           <= '0;
      r_valid         <= '0;
      r_found         <= 1'b0;
      r_map           <= '0;
      r_romsz         <= '0;
      r_ramsz         <= '0;
      r_cc            <= '0;
      r_ck            <= '0;
      r_vec           <= '0;
      r_parser_resetn <= 1'b1;
      r_hdr_d         <= '0;
      r_hdr_strb      <= 1'b0;
      r_hdr_base      <= '0;
      r_hdr_sel       <= '0;
      r_hdr_score     <= '0;
      r_none_valid    <= 1'b0;
    end else begin
      r_hdr_strb      <= 1'b0;
      r_parser_resetn <= (w_state_nxt != S_RSTP);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_valid      <= w_valid_in;
            r_found      <= 1'b0;
            r_win        <= '0;
            r_off        <= '0;
            r_hdr_sel    <= '0;
            r_hdr_score  <= '0;
            r_hdr_base   <= '0;
            r_none_valid <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!r_mem_req) begin
            if (w_first_ok) begin
              r_mem_req  <= 1'b1;
              r_win      <= w_first;
              r_off      <= '0;
              r_mem_addr <= AW'(win_base(w_first));
            end
          end else if (w_ack) begin
            case (r_off)
              6'h15:   r_map      <= mem.mem_rdata;
              6'h17:   r_romsz    <= mem.mem_rdata;
              6'h18:   r_ramsz    <= mem.mem_rdata;
              6'h1C:   r_cc[7:0]  <= mem.mem_rdata;
              6'h1D:   r_cc[15:8] <= mem.mem_rdata;
              6'h1E:   r_ck[7:0]  <= mem.mem_rdata;
              6'h1F:   r_ck[15:8] <= mem.mem_rdata;
              6'h3C:   r_vec[7:0] <= mem.mem_rdata;
              6'h3D:   r_vec[15:8] <= mem.mem_rdata;
              default: ;
            endcase
            if (w_last) begin
              // The first valid window is always taken; later ones must beat it.
              if (!r_found || (w_score > r_hdr_score)) begin
                r_hdr_sel   <= r_win;
                r_hdr_score <= w_score;
                r_found     <= 1'b1;
              end
              if (w_next_ok) begin
                r_win      <= w_next;
                r_off      <= '0;
                r_mem_addr <= AW'(win_base(w_next));
              end else begin
                r_mem_req <= 1'b0;
              end
            end else begin
              r_off      <= r_off + 6'd1;
              r_mem_addr <= r_mem_addr + AW'(1);
            end
          end
        end
        S_PICK: begin
          r_none_valid <= !r_found;
          r_hdr_base   <= win_base(r_hdr_sel);
        end
        S_RSTP: begin
          r_mem_req  <= 1'b1;
          r_off      <= '0;
          r_mem_addr <= AW'(r_hdr_base);
        end
        S_STREAM: begin
          if (w_ack) begin
            r_hdr_d    <= mem.mem_rdata;
            r_hdr_strb <= 1'b1;
            if (w_last) begin
              r_mem_req <= 1'b0;
            end else begin
              r_off      <= r_off + 6'd1;
              r_mem_addr <= r_mem_addr + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req    = r_mem_req;
  assign mem.mem_addr   = r_mem_addr;
  assign parser_resetn  = r_parser_resetn;
  assign hdr_d          = r_hdr_d;
  assign hdr_strb       = r_hdr_strb;
  assign hdr_base       = r_hdr_base;
  assign hdr_sel        = r_hdr_sel;
  assign hdr_score      = r_hdr_score;
  assign none_valid     = r_none_valid;
  assign busy           = (r_state == S_SCAN) || (r_state == S_PICK) ||
                          (r_state == S_RSTP) || (r_state == S_STREAM);
  assign done           = (r_state == S_DONE);

endmodule

// File: tb/tb_snes_header_finder.sv
// Directed bench for snes_header_finder: a byte-addressed memory model with
// zero-wait or random-latency acknowledges, plus monitors for the read
// addresses, the parser byte stream and the parser reset pulse.
module tb_snes_header_finder;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [23:0] rom_bytes;
  logic        parser_resetn;
  logic [7:0]  hdr_d;
  logic        hdr_strb;
  logic [23:0] hdr_base;
  logic [1:0]  hdr_sel;
  logic [3:0]  hdr_score;
  logic        none_valid;
  logic        busy;
  logic        done;

  snes_header_finder_if #(.AW(23)) mif ();

  snes_header_finder #(.AW(23)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .rom_bytes     (rom_bytes),
    .mem           (mif),
    .parser_resetn (parser_resetn),
    .hdr_d         (hdr_d),
    .hdr_strb      (hdr_strb),
    .hdr_base      (hdr_base),
    .hdr_sel       (hdr_sel),
    .hdr_score     (hdr_score),
    .none_valid    (none_valid),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [int];
  int         rd_log[$];
  logic [7:0] strb_log[$];
  int         prst_cnt, prst_early, addr_viol;
  bit         rand_lat = 1'b0;
  bit         in_flight = 1'b0;
  int         held_addr, wait_left;
  logic       req_at2;
  int         cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wbase(input int w);
    case (w)
      0:       return 32'h007FC0;
      1:       return 32'h00FFC0;
      default: return 32'h40FFC0;
    endcase
  endfunction

  function automatic logic [7:0] rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Fills one 64-byte window with a position-dependent pattern, then places
  // the scored fields at their offsets.
  task automatic load_window(input int w, input logic [7:0] map, input logic [7:0] rs,
                             input logic [7:0] ram, input logic [15:0] cc,
                             input logic [15:0] ck, input logic [15:0] vec);
    int b;
    b = wbase(w);
    for (int i = 0; i < 64; i++) mem[b + i] = 8'(i * 3 + w * 17 + 1);
    mem[b + 'h15] = map;
    mem[b + 'h17] = rs;
    mem[b + 'h18] = ram;
    mem[b + 'h1C] = cc[7:0];
    mem[b + 'h1D] = cc[15:8];
    mem[b + 'h1E] = ck[7:0];
    mem[b + 'h1F] = ck[15:8];
    mem[b + 'h3C] = vec[7:0];
    mem[b + 'h3D] = vec[15:8];
  endtask

  // Memory responder: holds a request until its latency expires, then acks.
  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mif.mem_ack = 1'b0;
      if (!mif.mem_req) begin
        in_flight = 1'b0;
        if (rand_lat && ($urandom_range(0, 3) == 0)) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = 8'hEE;
        end
      end else begin
        if (!in_flight) begin
          in_flight = 1'b1;
          held_addr = int'(mif.mem_addr);
          wait_left = rand_lat ? int'($urandom_range(0, 7)) : 0;
        end
        if (int'(mif.mem_addr) != held_addr) addr_viol++;
        if (wait_left == 0) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = rd(int'(mif.mem_addr));
          rd_log.push_back(int'(mif.mem_addr));
          in_flight = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Parser-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (hdr_strb) strb_log.push_back(hdr_d);
      if (!parser_resetn) begin
        prst_cnt++;
        if (strb_log.size() == 0) prst_early++;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    strb_log.delete();
    prst_cnt   = 0;
    prst_early = 0;
    addr_viol  = 0;
  endtask

  // One start-to-done run; optionally injects a start (with a bogus size) mid-run.
  task automatic run(input logic [23:0] rb, input bit inject, output int cycles);
    clear_logs();
    rom_bytes = rb;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    check("busy_after_start", busy, 1'b1);
    check("done_after_start", done, 1'b0);
    check("no_req_setup", mif.mem_req, 1'b0);
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 2) req_at2 = mif.mem_req;
      if (inject && cycles == 40) begin
        start     = 1'b1;
        rom_bytes = 24'h000100;
      end else if (inject && cycles == 41) begin
        start     = 1'b0;
        rom_bytes = rb;
      end
    end
    check("done_reached", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
  endtask

  // Expected read sequence: every fitting window in order, then the chosen one.
  task automatic chk_reads(input string tag, input logic [23:0] rb, input int exp_base);
    int exp_q[$];
    int bad;
    bad = 0;
    for (int w = 0; w < 3; w++)
      if (wbase(w) + 64 <= int'(rb))
        for (int i = 0; i < 64; i++) exp_q.push_back(wbase(w) + i);
    for (int i = 0; i < 64; i++) exp_q.push_back(exp_base + i);
    check({tag, "_nreads"}, rd_log.size(), exp_q.size());
    foreach (exp_q[i])
      if (i >= rd_log.size() || rd_log[i] != exp_q[i]) bad++;
    check({tag, "_read_addrs"}, bad, 0);
  endtask

  task automatic chk_stream(input string tag, input int base);
    int bad;
    bad = 0;
    check({tag, "_nstrobes"}, strb_log.size(), 64);
    for (int i = 0; i < 64; i++)
      if (i >= strb_log.size() || strb_log[i] !== rd(base + i)) bad++;
    check({tag, "_stream_bytes"}, bad, 0);
    check({tag, "_prst_cycles"}, prst_cnt, 1);
    check({tag, "_prst_before_strb"}, prst_early, 1);
  endtask

  task automatic chk_result(input string tag, input logic [1:0] sel, input logic [3:0] score,
                            input logic [23:0] base, input logic nv);
    check({tag, "_sel"}, hdr_sel, sel);
    check({tag, "_score"}, hdr_score, score);
    check({tag, "_base"}, hdr_base, base);
    check({tag, "_none_valid"}, none_valid, nv);
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    rom_bytes = 24'h0;
    req_at2   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_mem_req", mif.mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_parser_resetn", parser_resetn, 1'b1);
    check("rst_hdr_strb", hdr_strb, 1'b0);
    check("rst_mem_addr", mif.mem_addr, 0);
    resetn = 1'b1;
    @(negedge clk);

    // HiROM image: window 0 scores 2, window 1 scores 8, window 2 does not fit.
    load_window(0, 8'h00, 8'h00, 8'hFF, 16'h0000, 16'h0000, 16'h0000);
    load_window(1, 8'h21, 8'h0A, 8'h00, 16'h1234, 16'hEDCB, 16'h8000);
    run(24'h100000, 1'b0, cyc);
    check("hirom_cycles", cyc, 197);
    check("hirom_first_req", req_at2, 1'b1);
    chk_result("hirom", 2'd1, 4'd8, 24'h00FFC0, 1'b0);
    chk_reads("hirom", 24'h100000, 32'h00FFC0);
    chk_stream("hirom", 32'h00FFC0);

    // LoROM 32 KB image: only window 0 fits (exactly), score 5.
    load_window(0, 8'h20, 8'h09, 8'h03, 16'h0000, 16'h0000, 16'h1234);
    run(24'h008000, 1'b0, cyc);
    check("lorom_cycles", cyc, 133);
    chk_result("lorom", 2'd0, 4'd5, 24'h007FC0, 1'b0);
    chk_reads("lorom", 24'h008000, 32'h007FC0);
    chk_stream("lorom", 32'h007FC0);

    // Tie 5/5 between windows 0 and 1; window 2 fits at the exact boundary, scores 4.
    load_window(1, 8'h31, 8'h20, 8'hFF, 16'hAAAA, 16'h5555, 16'h7FFF);
    load_window(2, 8'h25, 8'h0D, 8'h09, 16'h0000, 16'h0000, 16'h0000);
    run(24'h410000, 1'b0, cyc);
    check("tie_cycles", cyc, 261);
    chk_result("tie", 2'd0, 4'd5, 24'h007FC0, 1'b0);
    chk_reads("tie", 24'h410000, 32'h007FC0);
    chk_stream("tie", 32'h007FC0);

    // Nothing fits: window 0 is streamed anyway with score 0.
    run(24'h000100, 1'b0, cyc);
    check("none_cycles", cyc, 69);
    chk_result("none", 2'd0, 4'd0, 24'h007FC0, 1'b1);
    chk_reads("none", 24'h000100, 32'h007FC0);
    chk_stream("none", 32'h007FC0);

    // Random ack latency, stray acks and an ignored start; window 2 scores 8.
    load_window(2, 8'h35, 8'h08, 8'h08, 16'h00FF, 16'hFF00, 16'hFFFF);
    rand_lat = 1'b1;
    run(24'h410000, 1'b1, cyc);
    rand_lat = 1'b0;
    chk_result("rand", 2'd2, 4'd8, 24'h40FFC0, 1'b0);
    chk_reads("rand", 24'h410000, 32'h40FFC0);
    chk_stream("rand", 32'h40FFC0);
    check("rand_addr_stable", addr_viol, 0);

    // Reset in the middle of streaming, then a clean rerun.
    load_window(1, 8'h21, 8'h0A, 8'h00, 16'h1234, 16'hEDCB, 16'h8000);
    clear_logs();
    rom_bytes = 24'h100000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (strb_log.size() < 20 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_byte20", strb_log.size() >= 20, 1'b1);
    resetn = 1'b0;
    #1;
    check("abort_mem_req", mif.mem_req, 1'b0);
    check("abort_mem_addr", mif.mem_addr, 0);
    check("abort_hdr_strb", hdr_strb, 1'b0);
    check("abort_hdr_d", hdr_d, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_parser_resetn", parser_resetn, 1'b1);
    chk_result("abort", 2'd0, 4'd0, 24'h000000, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    run(24'h100000, 1'b0, cyc);
    check("rerun_cycles", cyc, 197);
    chk_result("rerun", 2'd1, 4'd8, 24'h00FFC0, 1'b0);
    chk_reads("rerun", 24'h100000, 32'h00FFC0);
    chk_stream("rerun", 32'h00FFC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_header_finder.md
# snes_header_finder

Locates the internal SNES cartridge header in a freshly loaded ROM image and replays it to the header parser. After the loader signals completion, it reads the three candidate header windows (LoROM, HiROM, ExHiROM) from cartridge memory and scores each one. It picks the best window, then streams that window's 64 bytes to the parser's `rom_d`/`rom_strb` input. It also resets the parser before the stream, so a new image can be re-detected without a global reset.

## Interface
Parameters:
- `AW`, default 23: byte address width of cartridge memory.

Ports:
- `clk`, in, 1: system clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse meaning the ROM load is complete. Ignored while `busy`.
- `rom_bytes`, in, 24: number of bytes loaded. Sampled on `start`.
- `mem_req`, out, 1: memory read request.
- `mem_addr`, out, AW: byte address of the read.
- `mem_ack`, in, 1: one-cycle pulse that completes the current read.
- `mem_rdata`, in, 8: read data, valid in the `mem_ack` cycle.
- `parser_resetn`, out, 1: synchronous active-low reset to the parser.
- `hdr_d`, out, 8: header byte to the parser.
- `hdr_strb`, out, 1: one-cycle byte strobe to the parser.
- `hdr_base`, out, 24: start address of the chosen header window.
- `hdr_sel`, out, 2: chosen window. 0 = LoROM, 1 = HiROM, 2 = ExHiROM.
- `hdr_score`, out, 4: score of the chosen window.
- `none_valid`, out, 1: no window fits inside `rom_bytes`.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: operation complete.

## Operation
- Candidate windows:
  - Window 0 (LoROM) starts at 0x007FC0.
  - Window 1 (HiROM) starts at 0x00FFC0.
  - Window 2 (ExHiROM) starts at 0x40FFC0.
  - Each window is 64 bytes, offsets 0x00–0x3F.
  - A window is valid only if base + 64 <= `rom_bytes`. Invalid windows are skipped without any memory read.
- States: IDLE → SCAN → PICK → RSTP → STREAM → DONE. A `start` in DONE behaves as in IDLE.
- SCAN:
  - For each valid window in order 0, 1, 2, read offsets 0x00–0x3F sequentially.
  - Latch bytes 0x15, 0x17, 0x18, 0x1C–0x1F, 0x3C and 0x3D.
  - Compute the score after offset 0x3F of each window.
- Score (4-bit unsigned, maximum 8):
  - +2 if the map byte (0x15) matches the window:
    - window 0: bit0 = 0;
    - window 1: bit0 = 1 and bit2 = 0;
    - window 2: bits[2:0] = 3'b101.
  - +1 if map[7:4] is 2 or 3.
  - +1 if the ROM size byte (0x17) is in 8..13.
  - +1 if the RAM size byte (0x18) is <= 8.
  - +2 if {0x1D,0x1C} ^ {0x1F,0x1E} == 16'hFFFF.
  - +1 if the reset vector {0x3D,0x3C} is >= 16'h8000.
- PICK:
  - A window replaces the current best only if its score is strictly greater. Ties therefore keep the lower index.
  - If no window is valid: select 0, score 0, `none_valid` = 1.
- RSTP: drive `parser_resetn` low for exactly one cycle.
- STREAM:
  - Re-read the chosen window at offsets 0x00–0x3F.
  - On each `mem_ack`, the next cycle has `hdr_strb` = 1 and `hdr_d` = that byte.
  - Exactly 64 strobes, in ascending offset order.
  - If `none_valid` = 1, stream window 0 anyway. Addresses beyond `rom_bytes` are still read.
- DONE:
  - `done` = 1 and `busy` = 0.
  - `hdr_base`, `hdr_sel`, `hdr_score` and `none_valid` hold until the next `start`.

## Timing
- Reset values:
  - `mem_req`, `hdr_strb`, `busy`, `done`, `none_valid` = 0.
  - `parser_resetn` = 1.
  - `mem_addr`, `hdr_d`, `hdr_base`, `hdr_sel`, `hdr_score` = 0.
  - State = IDLE.
- `start` accepted in IDLE or DONE:
  - `busy` = 1 and `done` = 0 the next cycle.
  - The first `mem_req` follows in the cycle after that.
  - A `start` while `busy` is ignored.
- Memory handshake:
  - `mem_req` is a level signal. `mem_addr` is stable while `mem_req` = 1 until `mem_ack`.
  - One read outstanding at a time.
  - In the cycle after `mem_ack`, `mem_addr` advances and `mem_req` stays high if more bytes remain. Otherwise `mem_req` drops.
  - `mem_ack` while `mem_req` = 0 is ignored.
- With zero-wait ack (ack in the first `mem_req` cycle), each byte costs 1 cycle.
  - Total from `start` to `done` with three valid windows: 2 + 192 + 1 (PICK) + 1 (RSTP) + 64 + 1 cycles.
- Strobe spacing: `hdr_strb` pulses are never adjacent-merged; each is high for exactly 1 cycle. `parser_resetn` goes low at least 1 cycle before the first strobe.
- `resetn` asserted mid-operation: everything returns to reset values immediately and any pending read is abandoned. The memory side must tolerate a request that is withdrawn before `mem_ack`.
- `done` rises the cycle after the 64th strobe.

## Test plan
- HiROM image: `rom_bytes` = 0x100000; window 1 has map 0x21, ROM size 0x0A, RAM size 0, checksum pair valid, vector 0x8000; window 0 is filler → `hdr_sel` = 1, `hdr_score` = 8, `hdr_base` = 0x00FFC0, 64 strobes carrying window-1 bytes in order.
- LoROM image: `rom_bytes` = 0x8000 (32 KB) → windows 1 and 2 are invalid with no reads issued; 64 SCAN reads plus 64 STREAM reads at 0x7FC0–0x7FFF; `hdr_sel` = 0.
- Tie: windows 0 and 1 both score 5 → `hdr_sel` = 0.
- `rom_bytes` = 0x100 → `none_valid` = 1, `hdr_score` = 0, stream from 0x7FC0; `done` = 1.
- Random `mem_ack` latency of 0–7 cycles with a `start` pulse injected while `busy` → identical results, `start` ignored, `mem_addr` never changes while a read is outstanding.
- `resetn` pulled low during STREAM at byte 20, then `start` again → all outputs return to reset values; the rerun gives a full 64 strobes preceded by a `parser_resetn` low pulse.
